// File: rtl/aes_word_loader.sv
// Word-stream front end for the AES core: packs 32-bit words into a 128-bit key
// and plaintext block, then holds the pair under a block-level valid/ready handshake.
module aes_word_loader #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      s_word,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             key_reuse,
   output logic [0:127]     plain_data,
   output logic [0:127]     key_input,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [CNT_W-1:0] blk_cnt,
   output logic             err_nokey
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD_KEY = 2'd1,
      LOAD_PT  = 2'd2,
      PRESENT  = 2'd3
   } state_e;

   state_e           state_q;
   logic [1:0]       idx_q;
   logic             key_loaded_q;
   logic [0:127]     key_q;
   logic [0:127]     pt_q;
   logic             blk_valid_q;
   logic             s_ready_q;
   logic [CNT_W-1:0] blk_cnt_q;
   logic             err_nokey_q;

   logic             accept;
   logic [6:0]       base;

   assign accept = s_valid && s_ready_q;
   // Word k of a group occupies bits [32k : 32k+31], word 0 at the MSB end.
   assign base   = {idx_q, 5'd0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         key_loaded_q <= 1'b0;
         key_q        <= '0;
         pt_q         <= '0;
         blk_valid_q  <= 1'b0;
         s_ready_q    <= 1'b1;
         blk_cnt_q    <= '0;
         err_nokey_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  idx_q <= 2'd1;
                  if (key_reuse && key_loaded_q) begin
                     pt_q[0:31] <= s_word;
                     state_q    <= LOAD_PT;
                  end else begin
                     // A reuse request with no key on file is flagged and parsed as a full frame.
                     if (key_reuse) begin
                        err_nokey_q <= 1'b1;
                     end
                     key_q[0:31] <= s_word;
                     state_q     <= LOAD_KEY;
                  end
               end
            end
            LOAD_KEY: begin
               if (accept) begin
                  key_q[base +: 32] <= s_word;
                  idx_q             <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     key_loaded_q <= 1'b1;
                     state_q      <= LOAD_PT;
                  end
               end
            end
            LOAD_PT: begin
               if (accept) begin
                  pt_q[base +: 32] <= s_word;
                  idx_q            <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     blk_valid_q <= 1'b1;
                     s_ready_q   <= 1'b0;
                     state_q     <= PRESENT;
                  end
               end
            end
            PRESENT: begin
               if (blk_ready) begin
                  blk_valid_q <= 1'b0;
                  s_ready_q   <= 1'b1;
                  blk_cnt_q   <= blk_cnt_q + CNT_W'(1);
                  idx_q       <= 2'd0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_ready    = s_ready_q;
   assign plain_data = pt_q;
   assign key_input  = key_q;
   assign blk_valid  = blk_valid_q;
   assign blk_cnt    = blk_cnt_q;
   assign err_nokey  = err_nokey_q;

endmodule

// File: tb/tb_aes_word_loader.sv
// Scoreboard bench for aes_word_loader: frames are modelled as they are driven,
// delivered blocks are popped and compared at the block handshake.
module tb_aes_word_loader;

   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [127:0] key;
      logic [127:0] pt;
   } blk_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      s_word;
   logic             s_valid;
   logic             s_ready;
   logic             key_reuse;
   logic [0:127]     plain_data;
   logic [0:127]     key_input;
   logic             blk_valid;
   logic             blk_ready;
   logic [CNT_W-1:0] blk_cnt;
   logic             err_nokey;

   int total = 0;
   int bad   = 0;

   blk_t             sb_q[$];
   logic [127:0]     m_key;
   bit               m_key_ok;
   bit               m_err;
   logic [CNT_W-1:0] exp_cnt;

   aes_word_loader #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_word     (s_word),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .key_reuse  (key_reuse),
      .plain_data (plain_data),
      .key_input  (key_input),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .blk_cnt    (blk_cnt),
      .err_nokey  (err_nokey)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Handshake is seen at the negedge before the consuming posedge.
   always @(negedge clk) begin
      if (!rst && blk_valid && blk_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_empty", 128'(1), 128'(0));
         end else begin
            blk_t e;
            e = sb_q.pop_front();
            check("key", 128'(key_input), e.key);
            check("pt", 128'(plain_data), e.pt);
            check("cnt", 128'(blk_cnt), 128'(exp_cnt));
            exp_cnt = exp_cnt + CNT_W'(1);
         end
      end
   end

   task automatic do_reset();
      rst       = 1'b1;
      s_valid   = 1'b0;
      @(posedge clk); #1;
      rst       = 1'b0;
      m_key_ok  = 1'b0;
      m_err     = 1'b0;
      exp_cnt   = '0;
      sb_q.delete();
      check("rst_pt", 128'(plain_data), 128'(0));
      check("rst_key", 128'(key_input), 128'(0));
      check("rst_vld", 128'(blk_valid), 128'(0));
      check("rst_cnt", 128'(blk_cnt), 128'(0));
      check("rst_err", 128'(err_nokey), 128'(0));
      check("rst_rdy", 128'(s_ready), 128'(1));
   endtask

   task automatic push_word(input logic [31:0] w, input bit rnd);
      int n;
      bit acc;
      if (rnd) begin
         while ($urandom_range(0, 1) == 0) begin
            s_valid = 1'b0;
            s_word  = $urandom;
            @(posedge clk); #1;
         end
      end
      s_valid = 1'b1;
      s_word  = w;
      n   = 0;
      acc = 1'b0;
      while (!acc) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk); #1;
         if (!acc) begin
            n++;
            if (n > 100) begin
               check("word_tmo", 128'(0), 128'(1));
               break;
            end
         end
      end
      s_valid = 1'b0;
      s_word  = $urandom;
   endtask

   task automatic send_frame(input logic [127:0] key, input logic [127:0] pt,
                             input bit reuse, input bit rnd, input bit wait_done);
      bit eff;
      bit first;
      blk_t e;
      eff = reuse && m_key_ok;
      if (reuse && !m_key_ok) m_err = 1'b1;
      if (!eff) begin
         m_key    = key;
         m_key_ok = 1'b1;
      end
      e.key = m_key;
      e.pt  = pt;
      sb_q.push_back(e);
      key_reuse = reuse;
      first = 1'b1;
      if (!eff) begin
         for (int k = 0; k < 4; k++) begin
            push_word(32'(key >> (96 - 32 * k)), rnd);
            if (first) key_reuse = 1'($urandom_range(0, 1));
            first = 1'b0;
         end
      end
      for (int k = 0; k < 3; k++) begin
         push_word(32'(pt >> (96 - 32 * k)), rnd);
         if (first) key_reuse = 1'($urandom_range(0, 1));
         first = 1'b0;
      end
      check("vld_early", 128'(blk_valid), 128'(0));
      push_word(32'(pt), rnd);
      check("vld_lat", 128'(blk_valid), 128'(1));
      check("rdy_low", 128'(s_ready), 128'(0));
      if (wait_done) begin
         @(posedge clk); #1;
         check("vld_drop", 128'(blk_valid), 128'(0));
         check("rdy_back", 128'(s_ready), 128'(1));
         check("cnt_after", 128'(blk_cnt), 128'(exp_cnt));
      end
      check("err", 128'(err_nokey), 128'(m_err));
   endtask

   initial begin
      logic [127:0] k0;
      logic [127:0] p0;
      rst       = 1'b1;
      s_word    = '0;
      s_valid   = 1'b0;
      key_reuse = 1'b0;
      blk_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Full frame, then a key-reuse frame.
      k0 = 128'h000102030405060708090a0b0c0d0e0f;
      send_frame(k0, 128'h00112233445566778899aabbccddeeff, 1'b0, 1'b0, 1'b1);
      check("cnt1", 128'(blk_cnt), 128'(1));
      send_frame(128'hffff, 128'h3243f6a8885a308d313198a2e0370734, 1'b1, 1'b0, 1'b1);
      check("cnt2", 128'(blk_cnt), 128'(2));
      check("key_kept", 128'(key_input), k0);

      // Downstream stall with a word waiting on the stream.
      blk_ready = 1'b0;
      p0 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      send_frame(128'h1111, p0, 1'b1, 1'b0, 1'b0);
      s_valid = 1'b1;
      s_word  = 32'hdeadbeef;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_rdy", 128'(s_ready), 128'(0));
         check("stall_vld", 128'(blk_valid), 128'(1));
         check("stall_pt", 128'(plain_data), p0);
         check("stall_key", 128'(key_input), k0);
      end
      @(posedge clk); #1;
      blk_ready = 1'b1;
      @(posedge clk); #1;
      check("rel_vld", 128'(blk_valid), 128'(0));
      check("rel_rdy", 128'(s_ready), 128'(1));
      send_frame(128'hdeadbeef0123456789abcdeffedcba98, 128'h55aa55aa00ff00ff12345678cafef00d,
                 1'b0, 1'b0, 1'b1);
      check("cnt3", 128'(blk_cnt), 128'(0));

      // Key reuse with no key on file.
      do_reset();
      send_frame(128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3, 128'h0123456789abcdef0011223344556677,
                 1'b1, 1'b0, 1'b1);
      check("nokey_err", 128'(err_nokey), 128'(1));
      send_frame(128'h77, 128'h99, 1'b0, 1'b0, 1'b1);
      check("nokey_sticky", 128'(err_nokey), 128'(1));

      // Abort after 5 words, then a clean frame.
      key_reuse = 1'b0;
      for (int i = 0; i < 5; i++) push_word(32'hbad00000 + 32'(i), 1'b0);
      do_reset();
      send_frame(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                 1'b0, 1'b0, 1'b1);
      check("abort_cnt", 128'(blk_cnt), 128'(1));

      // Counter wrap with random stream gaps.
      do_reset();
      for (int f = 0; f < 3; f++)
         send_frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    1'b0, 1'b0, 1'b1);
      check("pre_wrap", 128'(blk_cnt), 128'(3));
      for (int f = 0; f < 3; f++) begin
         send_frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    1'($urandom_range(0, 1)), 1'b1, 1'b1);
         if (f == 0) check("wrap0", 128'(blk_cnt), 128'(0));
      end
      check("post_wrap", 128'(blk_cnt), 128'(2));

      check("sb_left", 128'(sb_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
